// File: rtl/readback_vout_arb_if.sv
// rtl/readback_vout_arb_if.sv - channel request, DDR read and readback stream signals of readback_vout_arb
//
// Purpose: bundles every non-clock/reset signal of readback_vout_arb.
// Modports:
//   slave  - the arbiter side (readback_vout_arb binds to this).
//   master - the environment side (channels, DDR read port, downstream sink).
// Signals:
//   ch_req_i / ch_addr_i / ch_ack_o       - per-channel burst request, start address, grant pulse
//   rd_ddr_req_o / rd_ddr_len_o / rd_ddr_addr_o - DDR read request pulse, beat count, address
//   rd_ddr_data_valid_i / rd_ddr_data_i / rd_ddr_finish_i - DDR read beats and burst-done pulse
//   readback_vld_o / readback_rdy_i / readback_data_o / readback_last_o / readback_ch_o - word stream
//   busy_o / err_o                        - activity and sticky error flags
`timescale 1ns/1ps
interface readback_vout_arb_if #(
  parameter int ADDR_WIDTH    = 30,
  parameter int DATA_WIDTH    = 32,
  parameter int MEM_DATA_BITS = 256,
  parameter int NUM_CH        = 4
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0]            ch_req_i;
  logic [NUM_CH*ADDR_WIDTH-1:0] ch_addr_i;
  logic [NUM_CH-1:0]            ch_ack_o;
  logic                         rd_ddr_req_o;
  logic [7:0]                   rd_ddr_len_o;
  logic [ADDR_WIDTH-1:0]        rd_ddr_addr_o;
  logic                         rd_ddr_data_valid_i;
  logic [MEM_DATA_BITS-1:0]     rd_ddr_data_i;
  logic                         rd_ddr_finish_i;
  logic                         readback_vld_o;
  logic                         readback_rdy_i;
  logic [DATA_WIDTH-1:0]        readback_data_o;
  logic                         readback_last_o;
  logic [CH_W-1:0]              readback_ch_o;
  logic                         busy_o;
  logic                         err_o;

  modport slave (
    input  ch_req_i, ch_addr_i, rd_ddr_data_valid_i, rd_ddr_data_i, rd_ddr_finish_i, readback_rdy_i,
    output ch_ack_o, rd_ddr_req_o, rd_ddr_len_o, rd_ddr_addr_o, readback_vld_o, readback_data_o,
           readback_last_o, readback_ch_o, busy_o, err_o
  );

  modport master (
    output ch_req_i, ch_addr_i, rd_ddr_data_valid_i, rd_ddr_data_i, rd_ddr_finish_i, readback_rdy_i,
    input  ch_ack_o, rd_ddr_req_o, rd_ddr_len_o, rd_ddr_addr_o, readback_vld_o, readback_data_o,
           readback_last_o, readback_ch_o, busy_o, err_o
  );
endinterface

// File: rtl/readback_vout_arb.sv
// rtl/readback_vout_arb.sv - round-robin DDR burst reader with beat FIFO and word downconverter
//
// Purpose: arbitrates NUM_CH channel burst requests round-robin, issues one DDR read of
// BURST_LEN beats at a time, buffers beats in a FIFO, and streams each beat out as RATIO
// words over a valid/ready port tagged with the owning channel.
// Ports:
//   ddr_clk_i   - single clock
//   ddr_rst_n_i - asynchronous active-low reset
//   bus         - readback_vout_arb_if.slave (channel requests, DDR read port, readback stream, flags)
// Configuration macro: READBACK_LANE_SWAP_EN - when defined, each beat is emitted MSB word first.
`timescale 1ns/1ps
module readback_vout_arb #(
  parameter real TCQ           = 0.1,
  parameter int  ADDR_WIDTH    = 30,
  parameter int  DATA_WIDTH    = 32,
  parameter int  MEM_DATA_BITS = 256,
  parameter int  BURST_LEN     = 128,
  parameter int  NUM_CH        = 4,
  parameter int  FIFO_DEPTH    = 512
) (
  input  logic                 ddr_clk_i,
  input  logic                 ddr_rst_n_i,
  readback_vout_arb_if.slave   bus
);
  localparam int RATIO     = MEM_DATA_BITS / DATA_WIDTH;
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int LANE_W    = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int AW        = $clog2(FIFO_DEPTH);
  localparam int LVL_W     = $clog2(FIFO_DEPTH + 1);
  localparam int TAG_DEPTH = FIFO_DEPTH / BURST_LEN;
  localparam int TAG_AW    = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int TAG_LW    = $clog2(TAG_DEPTH + 1);
  localparam int WORDS     = BURST_LEN * RATIO;
  localparam int WCNT_W    = (WORDS > 1) ? $clog2(WORDS) : 1;

  localparam bit CFG_OK = (TCQ >= 0.0) && (RATIO >= 1) && (RATIO * DATA_WIDTH == MEM_DATA_BITS) &&
                          ((RATIO & (RATIO - 1)) == 0) && (BURST_LEN >= 1) && (BURST_LEN <= 255) &&
                          (NUM_CH >= 1) && (NUM_CH <= 16) && (FIFO_DEPTH >= 2 * BURST_LEN) &&
                          ((FIFO_DEPTH & (FIFO_DEPTH - 1)) == 0);
  generate
    if (!CFG_OK) begin : g_cfg_unsupported
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t                state_q;
  logic [NUM_CH-1:0]     ack_q;
  logic                  req_q;
  logic [7:0]            len_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [CH_W-1:0]       last_grant_q;
  logic [8:0]            beat_cnt_q;
  logic [8:0]            beat_cnt_d;

  logic [MEM_DATA_BITS-1:0] beat_mem [FIFO_DEPTH];
  logic [AW-1:0]            wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]         level_q;
  logic                     err_q;

  logic [CH_W-1:0]   tag_mem [TAG_DEPTH];
  logic [TAG_AW-1:0] tag_wr_ptr_q, tag_rd_ptr_q;
  logic [TAG_LW-1:0] tag_cnt_q;

  logic                  out_vld_q, out_last_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic [LANE_W-1:0]     lane_q, lane_sel;
  logic [WCNT_W-1:0]     wcnt_q;

  // Round-robin search starting just above the last granted channel.
  logic            grant_found;
  logic [CH_W-1:0] grant_idx;
  int              cand;
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int i = 1; i <= NUM_CH; i++) begin
      cand = (int'(last_grant_q) + i) % NUM_CH;
      if (!grant_found && bus.ch_req_i[cand]) begin
        grant_found = 1'b1;
        grant_idx   = CH_W'(cand);
      end
    end
  end

  logic in_wait, fifo_full, fifo_empty, space_ok, tag_full;
  logic load, xfer, pop, wr_en, drop_err, finish_err, tag_push, tag_pop, start;

  assign in_wait    = (state_q == S_WAIT);
  assign fifo_full  = (level_q == LVL_W'(FIFO_DEPTH));
  assign fifo_empty = (level_q == '0);
  assign space_ok   = (level_q <= LVL_W'(FIFO_DEPTH - BURST_LEN));
  assign tag_full   = (tag_cnt_q == TAG_LW'(TAG_DEPTH));
  assign start      = (state_q == S_IDLE) && grant_found && space_ok && !tag_full;

  // The output register refills whenever it is empty or its word leaves this cycle.
  assign load = !fifo_empty && (!out_vld_q || bus.readback_rdy_i);
  assign xfer = out_vld_q && bus.readback_rdy_i;
  assign pop  = load && (lane_q == LANE_W'(RATIO - 1));

  // A full FIFO still accepts a beat when the head beat retires in the same cycle.
  assign wr_en      = bus.rd_ddr_data_valid_i && in_wait && (!fifo_full || pop);
  assign drop_err   = bus.rd_ddr_data_valid_i && !wr_en;
  assign beat_cnt_d = beat_cnt_q + 9'(bus.rd_ddr_data_valid_i);
  assign finish_err = in_wait && bus.rd_ddr_finish_i && (beat_cnt_d != 9'(BURST_LEN));

  assign tag_push = (state_q == S_REQ);
  assign tag_pop  = xfer && out_last_q;

`ifdef READBACK_LANE_SWAP_EN
  assign lane_sel = LANE_W'(RATIO - 1) - lane_q;
`else
  assign lane_sel = lane_q;
`endif

  logic [MEM_DATA_BITS-1:0] head_beat;
  assign head_beat = beat_mem[rd_ptr_q];

  always_ff @(posedge ddr_clk_i or negedge ddr_rst_n_i) begin
    if (!ddr_rst_n_i) begin
      state_q      <= S_IDLE;
      ack_q        <= '0;
      req_q        <= 1'b0;
      len_q        <= '0;
      addr_q       <= '0;
      last_grant_q <= CH_W'(NUM_CH - 1);
      beat_cnt_q   <= '0;
    end else begin
      ack_q <= '0;
      req_q <= 1'b0;
      len_q <= '0;
      case (state_q)
        S_IDLE: if (start) begin
          state_q      <= S_REQ;
          ack_q        <= NUM_CH'(1) << grant_idx;
          req_q        <= 1'b1;
          len_q        <= 8'(BURST_LEN);
          addr_q       <= bus.ch_addr_i[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
          last_grant_q <= grant_idx;
        end
        S_REQ: begin
          state_q    <= S_WAIT;
          beat_cnt_q <= '0;
        end
        S_WAIT: begin
          beat_cnt_q <= beat_cnt_d;
          if (bus.rd_ddr_finish_i) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge ddr_clk_i) begin
    if (wr_en) beat_mem[wr_ptr_q] <= bus.rd_ddr_data_i;
    if (tag_push) tag_mem[tag_wr_ptr_q] <= last_grant_q;
  end

  always_ff @(posedge ddr_clk_i or negedge ddr_rst_n_i) begin
    if (!ddr_rst_n_i) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      err_q        <= 1'b0;
      tag_wr_ptr_q <= '0;
      tag_rd_ptr_q <= '0;
      tag_cnt_q    <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_q + LVL_W'(wr_en) - LVL_W'(pop);
      if (drop_err || finish_err) err_q <= 1'b1;
      if (tag_push)
        tag_wr_ptr_q <= (tag_wr_ptr_q == TAG_AW'(TAG_DEPTH - 1)) ? '0 : tag_wr_ptr_q + 1'b1;
      if (tag_pop)
        tag_rd_ptr_q <= (tag_rd_ptr_q == TAG_AW'(TAG_DEPTH - 1)) ? '0 : tag_rd_ptr_q + 1'b1;
      tag_cnt_q <= tag_cnt_q + TAG_LW'(tag_push) - TAG_LW'(tag_pop);
    end
  end

  always_ff @(posedge ddr_clk_i or negedge ddr_rst_n_i) begin
    if (!ddr_rst_n_i) begin
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
      out_last_q <= 1'b0;
      lane_q     <= '0;
      wcnt_q     <= '0;
    end else if (load) begin
      out_vld_q  <= 1'b1;
      out_data_q <= head_beat[lane_sel*DATA_WIDTH +: DATA_WIDTH];
      out_last_q <= (wcnt_q == WCNT_W'(WORDS - 1));
      wcnt_q     <= (wcnt_q == WCNT_W'(WORDS - 1)) ? '0 : wcnt_q + 1'b1;
      lane_q     <= (lane_q == LANE_W'(RATIO - 1)) ? '0 : lane_q + 1'b1;
    end else if (xfer) begin
      out_vld_q <= 1'b0;
    end
  end

  assign bus.ch_ack_o        = ack_q;
  assign bus.rd_ddr_req_o    = req_q;
  assign bus.rd_ddr_len_o    = len_q;
  assign bus.rd_ddr_addr_o   = addr_q;
  assign bus.readback_vld_o  = out_vld_q;
  assign bus.readback_data_o = out_data_q;
  assign bus.readback_last_o = out_last_q;
  // The tag head only advances when a last word leaves, so it names the channel of the held word.
  assign bus.readback_ch_o   = out_vld_q ? tag_mem[tag_rd_ptr_q] : '0;
  assign bus.busy_o          = (state_q != S_IDLE) || !fifo_empty;
  assign bus.err_o           = err_q;
endmodule

// File: tb/tb_readback_vout_arb.sv
// tb/tb_readback_vout_arb.sv - directed self-checking bench for readback_vout_arb
`timescale 1ns/1ps
module tb_readback_vout_arb;
  localparam int AW = 30, DW = 32, MB = 256, BL = 128, NC = 4, FD = 512, WORDS = 1024;
`ifdef READBACK_LANE_SWAP_EN
  localparam bit SWAP = 1'b1;
`else
  localparam bit SWAP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  readback_vout_arb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DATA_BITS(MB), .NUM_CH(NC)) bus ();

  readback_vout_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DATA_BITS(MB), .BURST_LEN(BL),
                      .NUM_CH(NC), .FIFO_DEPTH(FD)) dut (
    .ddr_clk_i(clk), .ddr_rst_n_i(rst_n), .bus(bus.slave));

  int n_cmp = 0, n_fail = 0;
  logic [31:0] got_data[$];
  bit          got_last[$];
  logic [1:0]  got_ch[$];
  bit prev_vld, prev_rdy, prev_last;
  logic [31:0] prev_data;
  logic [1:0]  prev_ch;
  int stab_err;

  function automatic logic [255:0] mk_beat(int base, int b);
    logic [255:0] v;
    for (int l = 0; l < 8; l++) v[l*32 +: 32] = 32'(base + b*8 + l);
    return v;
  endfunction

  function automatic logic [31:0] exp_word(int base, int k);
    int l;
    l = k % 8;
    if (SWAP) l = 7 - l;
    return 32'(base + (k/8)*8 + l);
  endfunction

  // Advance one cycle: record stall stability and transferred words, then sample 1ns after the edge.
  task automatic step();
    if (prev_vld && !prev_rdy && (bus.readback_vld_o !== 1'b1 || bus.readback_data_o !== prev_data ||
        bus.readback_last_o !== prev_last || bus.readback_ch_o !== prev_ch)) stab_err++;
    prev_vld = bus.readback_vld_o; prev_rdy = bus.readback_rdy_i; prev_data = bus.readback_data_o;
    prev_last = bus.readback_last_o; prev_ch = bus.readback_ch_o;
    if (bus.readback_vld_o && bus.readback_rdy_i) begin
      got_data.push_back(bus.readback_data_o);
      got_last.push_back(bus.readback_last_o);
      got_ch.push_back(bus.readback_ch_o);
    end
    @(posedge clk); #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    bus.ch_req_i = '0; bus.ch_addr_i = '0; bus.rd_ddr_data_valid_i = 1'b0;
    bus.rd_ddr_data_i = '0; bus.rd_ddr_finish_i = 1'b0; bus.readback_rdy_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    got_data.delete(); got_last.delete(); got_ch.delete();
    prev_vld = 1'b0; stab_err = 0;
  endtask

  task automatic wait_req(input int bound, output int ch, output bit ok);
    ok = 1'b0; ch = -1;
    for (int i = 0; i < bound; i++) begin
      if (bus.rd_ddr_req_o) begin
        ok = 1'b1;
        for (int k = 0; k < NC; k++) if (bus.ch_ack_o[k]) ch = k;
        step();
        return;
      end
      step();
    end
  endtask

  task automatic feed(input int base, input int nbeats, input bit do_finish, input bit rnd);
    for (int b = 0; b < nbeats; b++) begin
      if (rnd) bus.readback_rdy_i = 1'($urandom_range(0, 1));
      bus.rd_ddr_data_valid_i = 1'b1;
      bus.rd_ddr_data_i = mk_beat(base, b);
      step();
    end
    bus.rd_ddr_data_valid_i = 1'b0;
    bus.rd_ddr_data_i = '0;
    if (do_finish) begin
      bus.rd_ddr_finish_i = 1'b1;
      step();
      bus.rd_ddr_finish_i = 1'b0;
    end
  endtask

  task automatic drain(input int target, input int bound, input bit rnd);
    for (int i = 0; i < bound; i++) begin
      if (got_data.size() >= target) break;
      if (rnd) bus.readback_rdy_i = 1'($urandom_range(0, 1));
      step();
    end
    bus.readback_rdy_i = 1'b1;
  endtask

  function automatic logic [80:0] outs();
    return {bus.ch_ack_o, bus.rd_ddr_req_o, bus.rd_ddr_len_o, bus.rd_ddr_addr_o, bus.readback_vld_o,
            bus.readback_data_o, bus.readback_last_o, bus.readback_ch_o, bus.busy_o, bus.err_o};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    bus.ch_req_i = '0; bus.ch_addr_i = '0; bus.rd_ddr_data_valid_i = 1'b0;
    bus.rd_ddr_data_i = '0; bus.rd_ddr_finish_i = 1'b0; bus.readback_rdy_i = 1'b0;
    repeat (2) @(posedge clk); #1;
    n_cmp++; if (outs() !== '0) begin n_fail++; $display("FAIL reset_outputs got=%h want=0", outs()); end
    apply_reset();
    n_cmp++; if (outs() !== '0) begin n_fail++; $display("FAIL idle_after_release got=%h want=0", outs()); end
  endtask

  task automatic test_single_burst();
    bit seen;
    int derr, cerr, nlast;
    apply_reset();
    bus.readback_rdy_i = 1'b1;
    bus.ch_addr_i[2*AW +: AW] = 30'h100;
    bus.ch_req_i = 4'b0100;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (bus.rd_ddr_req_o) begin
        seen = 1'b1;
        n_cmp++; if (bus.ch_ack_o !== 4'b0100) begin n_fail++; $display("FAIL ack_ch2 got=%b want=0100", bus.ch_ack_o); end
        n_cmp++; if (bus.rd_ddr_len_o !== 8'd128) begin n_fail++; $display("FAIL req_len got=%0d want=128", bus.rd_ddr_len_o); end
        n_cmp++; if (bus.rd_ddr_addr_o !== 30'h100) begin n_fail++; $display("FAIL req_addr got=%h want=100", bus.rd_ddr_addr_o); end
        bus.ch_req_i = '0;
      end
      step();
    end
    n_cmp++; if (!seen) begin n_fail++; $display("FAIL req_timeout got=none want=rd_ddr_req"); end
    n_cmp++; if (bus.rd_ddr_req_o !== 1'b0 || bus.ch_ack_o !== 4'b0)
      begin n_fail++; $display("FAIL req_pulse_width got=%b/%b want=0/0000", bus.rd_ddr_req_o, bus.ch_ack_o); end
    for (int b = 0; b < BL; b++) begin
      bus.rd_ddr_data_valid_i = 1'b1;
      bus.rd_ddr_data_i = mk_beat(0, b);
      step();
      if (b == 0) begin
        n_cmp++; if (bus.readback_vld_o !== 1'b0) begin n_fail++; $display("FAIL latency_n1 got=%b want=0", bus.readback_vld_o); end
      end
      if (b == 1) begin
        n_cmp++; if (bus.readback_vld_o !== 1'b1 || bus.readback_data_o !== exp_word(0, 0))
          begin n_fail++; $display("FAIL latency_n2 got=%b/%h want=1/%h", bus.readback_vld_o, bus.readback_data_o, exp_word(0, 0)); end
      end
    end
    bus.rd_ddr_data_valid_i = 1'b0;
    bus.rd_ddr_finish_i = 1'b1; step(); bus.rd_ddr_finish_i = 1'b0;
    drain(WORDS, 1500, 1'b0);
    derr = 0; cerr = 0; nlast = 0;
    for (int k = 0; k < got_data.size(); k++) begin
      if (got_data[k] !== exp_word(0, k)) derr++;
      if (got_ch[k] !== 2'd2) cerr++;
      if (got_last[k]) nlast++;
    end
    n_cmp++; if (got_data.size() != WORDS) begin n_fail++; $display("FAIL burst_word_count got=%0d want=%0d", got_data.size(), WORDS); end
    n_cmp++; if (derr != 0) begin n_fail++; $display("FAIL burst_data got=%0d bad words want=0", derr); end
    n_cmp++; if (cerr != 0) begin n_fail++; $display("FAIL burst_ch got=%0d bad tags want=0", cerr); end
    n_cmp++; if (nlast != 1 || got_last.size() != WORDS || !got_last[WORDS-1])
      begin n_fail++; $display("FAIL burst_last got=%0d lasts want=1 on word 1023", nlast); end
    n_cmp++; if (bus.busy_o !== 1'b0 || bus.err_o !== 1'b0)
      begin n_fail++; $display("FAIL burst_idle got=busy %b err %b want=0/0", bus.busy_o, bus.err_o); end
  endtask

  task automatic test_round_robin();
    int exp_g[5] = '{0, 1, 2, 3, 0};
    int ch;
    bit ok;
    logic [1:0] last_ch[$];
    apply_reset();
    bus.readback_rdy_i = 1'b1;
    for (int k = 0; k < NC; k++) bus.ch_addr_i[k*AW +: AW] = 30'(32'h1000 * k);
    bus.ch_req_i = 4'hF;
    for (int g = 0; g < 5; g++) begin
      wait_req(3000, ch, ok);
      n_cmp++; if (!ok || ch != exp_g[g]) begin n_fail++; $display("FAIL rr_grant%0d got=%0d want=%0d", g, ch, exp_g[g]); end
      if (g == 4) bus.ch_req_i = '0;
      feed(32'h100000 * (g + 1), BL, 1'b1, 1'b0);
    end
    drain(5 * WORDS, 7000, 1'b0);
    for (int k = 0; k < got_last.size(); k++) if (got_last[k]) last_ch.push_back(got_ch[k]);
    n_cmp++; if (last_ch.size() != 5) begin n_fail++; $display("FAIL rr_burst_count got=%0d want=5", last_ch.size()); end
    for (int g = 0; g < last_ch.size() && g < 5; g++) begin
      n_cmp++; if (last_ch[g] !== 2'(exp_g[g])) begin n_fail++; $display("FAIL rr_out_ch%0d got=%0d want=%0d", g, last_ch[g], exp_g[g]); end
    end
  endtask

  task automatic test_random_rdy();
    int ch, derr, nlast;
    bit ok;
    apply_reset();
    bus.readback_rdy_i = 1'b1;
    bus.ch_addr_i[1*AW +: AW] = 30'h2000;
    bus.ch_req_i = 4'b0010;
    wait_req(20, ch, ok);
    bus.ch_req_i = '0;
    n_cmp++; if (!ok || ch != 1) begin n_fail++; $display("FAIL rnd_grant got=%0d want=1", ch); end
    feed(32'h70000, BL, 1'b1, 1'b1);
    drain(WORDS, 4000, 1'b1);
    derr = 0; nlast = 0;
    for (int k = 0; k < got_data.size(); k++) begin
      if (got_data[k] !== exp_word(32'h70000, k)) derr++;
      if (got_last[k]) nlast++;
    end
    n_cmp++; if (got_data.size() != WORDS) begin n_fail++; $display("FAIL rnd_word_count got=%0d want=%0d", got_data.size(), WORDS); end
    n_cmp++; if (derr != 0) begin n_fail++; $display("FAIL rnd_data got=%0d bad words want=0", derr); end
    n_cmp++; if (nlast != 1) begin n_fail++; $display("FAIL rnd_last got=%0d want=1", nlast); end
    n_cmp++; if (stab_err != 0) begin n_fail++; $display("FAIL rnd_stall_stable got=%0d changes want=0", stab_err); end
  endtask

  task automatic test_stall_backpressure();
    int ch, derr;
    bit ok, seen;
    apply_reset();
    bus.readback_rdy_i = 1'b0;
    bus.ch_addr_i[3*AW +: AW] = 30'h3000;
    bus.ch_req_i = 4'b1000;
    for (int g = 0; g < 4; g++) begin
      wait_req(200, ch, ok);
      n_cmp++; if (!ok || ch != 3) begin n_fail++; $display("FAIL stall_req%0d got=%0d want=3", g, ch); end
      feed(32'h10000 * (g + 1), BL, 1'b1, 1'b0);
    end
    seen = 1'b0;
    repeat (60) begin
      if (bus.rd_ddr_req_o) seen = 1'b1;
      step();
    end
    n_cmp++; if (seen) begin n_fail++; $display("FAIL stall_fifth_held got=issued want=held"); end
    n_cmp++; if (bus.err_o !== 1'b0) begin n_fail++; $display("FAIL stall_no_drop got=%b want=0", bus.err_o); end
    bus.readback_rdy_i = 1'b1;
    wait_req(1500, ch, ok);
    bus.ch_req_i = '0;
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL stall_fifth_issued got=none want=req"); end
    feed(32'h50000, BL, 1'b1, 1'b0);
    drain(5 * WORDS, 6000, 1'b0);
    derr = 0;
    for (int k = 0; k < got_data.size(); k++)
      if (got_data[k] !== exp_word(32'h10000 * (k / WORDS + 1), k % WORDS)) derr++;
    n_cmp++; if (got_data.size() != 5 * WORDS) begin n_fail++; $display("FAIL stall_word_count got=%0d want=%0d", got_data.size(), 5 * WORDS); end
    n_cmp++; if (derr != 0) begin n_fail++; $display("FAIL stall_data got=%0d bad words want=0", derr); end
    n_cmp++; if (stab_err != 0) begin n_fail++; $display("FAIL stall_stable got=%0d changes want=0", stab_err); end
  endtask

  task automatic test_short_burst_err();
    int ch;
    bit ok;
    apply_reset();
    bus.readback_rdy_i = 1'b1;
    bus.ch_req_i = 4'b0001;
    wait_req(20, ch, ok);
    bus.ch_req_i = '0;
    feed(32'h90000, 100, 1'b1, 1'b0);
    n_cmp++; if (bus.err_o !== 1'b1) begin n_fail++; $display("FAIL short_err_set got=%b want=1", bus.err_o); end
    drain(800, 1000, 1'b0);
    n_cmp++; if (bus.err_o !== 1'b1 || bus.busy_o !== 1'b0)
      begin n_fail++; $display("FAIL short_err_sticky got=err %b busy %b want=1/0", bus.err_o, bus.busy_o); end
    apply_reset();
    n_cmp++; if (bus.err_o !== 1'b0) begin n_fail++; $display("FAIL err_cleared got=%b want=0", bus.err_o); end
    bus.rd_ddr_data_valid_i = 1'b1; bus.rd_ddr_data_i = mk_beat(1, 1);
    step();
    bus.rd_ddr_data_valid_i = 1'b0;
    n_cmp++; if (bus.err_o !== 1'b1 || bus.busy_o !== 1'b0)
      begin n_fail++; $display("FAIL idle_beat got=err %b busy %b want=1/0", bus.err_o, bus.busy_o); end
  endtask

  task automatic test_reset_mid_wait();
    int ch;
    bit ok;
    apply_reset();
    bus.readback_rdy_i = 1'b1;
    bus.ch_req_i = 4'b0010;
    wait_req(20, ch, ok);
    bus.ch_req_i = '0;
    feed(32'hA0000, 50, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    n_cmp++; if (outs() !== '0) begin n_fail++; $display("FAIL midwait_reset got=%h want=0", outs()); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step(); step();
    n_cmp++; if (bus.busy_o !== 1'b0 || bus.readback_vld_o !== 1'b0)
      begin n_fail++; $display("FAIL midwait_release got=busy %b vld %b want=0/0", bus.busy_o, bus.readback_vld_o); end
  endtask

  task automatic test_lane_order();
    int ch;
    bit ok;
    apply_reset();
    bus.readback_rdy_i = 1'b1;
    bus.ch_req_i = 4'b0001;
    wait_req(20, ch, ok);
    bus.ch_req_i = '0;
    feed(0, BL, 1'b1, 1'b0);
    drain(WORDS, 1500, 1'b0);
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (got_data.size() <= i || got_data[i] !== (SWAP ? 32'(7 - i) : 32'(i)))
        begin n_fail++; $display("FAIL lane_order%0d got=%h want=%0d", i, (got_data.size() > i) ? got_data[i] : 32'hx, SWAP ? 7 - i : i); end
    end
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_round_robin();
    test_random_rdy();
    test_stall_backpressure();
    test_short_burst_err();
    test_reset_mid_wait();
    test_lane_order();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=completion");
    $fatal(1, "watchdog");
  end
endmodule
